// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Optional single-cycle multiply is selected with the MULDIV_FAST_MUL_EN macro.
package muldiv_unit_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 6;
  localparam int MD_STEPS = 32;

  // funct3 encodings of the M extension
  localparam logic [2:0] MD_OP_MUL    = 3'd0;
  localparam logic [2:0] MD_OP_MULH   = 3'd1;
  localparam logic [2:0] MD_OP_MULHSU = 3'd2;
  localparam logic [2:0] MD_OP_MULHU  = 3'd3;
  localparam logic [2:0] MD_OP_DIV    = 3'd4;
  localparam logic [2:0] MD_OP_DIVU   = 3'd5;
  localparam logic [2:0] MD_OP_REM    = 3'd6;
  localparam logic [2:0] MD_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_CALC = 2'd1,
    MD_ST_FIN  = 2'd2,
    MD_ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage (master) and the mul/div unit (slave).
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid holds its payload until then.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// 2*XLEN-bit {hi,lo} accumulator performing one radix-2 step per cycle:
// right-shifting shift-add multiply, or left-shifting restoring divide on magnitudes.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic [XLEN-1:0] hi_d, lo_d;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic [XLEN-1:0] rem_try;
  logic            fits;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shl     = {hi_q, lo_q[XLEN-1]};
    // when shl >= divisor the true difference fits in XLEN bits
    fits    = (shl >= {1'b0, opnd_q});
    rem_try = shl[XLEN-1:0] - opnd_q;
    hi_d    = sum[XLEN:1];
    lo_d    = {sum[0], lo_q[XLEN-1:1]};
    if (is_div) begin
      hi_d = fits ? rem_try : shl[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], fits};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (clr) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= a_i;
      opnd_q <= b_i;
    end else if (step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, handshake, special cases and sign fix-up around muldiv_iter_core.
// Define MULDIV_FAST_MUL_EN to compute multiplies in one cycle with a 33x33 signed multiplier.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  muldiv_unit_if.slave bus,
  output md_state_e    dbg_state_o
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic            neg_q_q, neg_r_q;
  logic            in_ready_q, out_valid_q;
  logic [XLEN-1:0] out_result_q;

  logic [2:0]      op;
  logic [XLEN-1:0] a, b, a_mag, b_mag;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic            special, fast_hit, core_load;
  logic [XLEN-1:0] special_res, fast_res, fin_res;
  logic [XLEN-1:0] core_hi, core_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] q_fix, r_fix;

  assign op       = bus.in_op;
  assign a        = bus.in_a;
  assign b        = bus.in_b;
  assign a_signed = (op == MD_OP_MULH) || (op == MD_OP_MULHSU) || (op == MD_OP_DIV) || (op == MD_OP_REM);
  assign b_signed = (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (op[2] && (b == '0)) begin
      special     = 1'b1;
      special_res = op[1] ? a : '1;
    end else if (((op == MD_OP_DIV) || (op == MD_OP_REM)) && (a == MIN_INT) && (b == '1)) begin
      special     = 1'b1;
      special_res = op[1] ? '0 : MIN_INT;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_prod;
  assign fast_a    = {a_signed & a[XLEN-1], a};
  assign fast_b    = {b_signed & b[XLEN-1], b};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (op == MD_OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  assign fast_hit  = ~op[2];
`else
  assign fast_res  = '0;
  assign fast_hit  = 1'b0;
`endif

  assign core_load = in_ready_q & bus.in_valid & ~flush & ~special & ~fast_hit;

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .load   (core_load),
    .step   (state_q == MD_ST_CALC),
    .is_div (op_q[2]),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  // Magnitude results are negated here; neg_q_q also carries the product sign for multiplies.
  always_comb begin
    prod_fix = neg_q_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    q_fix    = neg_q_q ? -core_lo : core_lo;
    r_fix    = neg_r_q ? -core_hi : core_hi;
    fin_res  = prod_fix[2*XLEN-1:XLEN];
    case (op_q)
      MD_OP_MUL:             fin_res = prod_fix[XLEN-1:0];
      MD_OP_DIV, MD_OP_DIVU: fin_res = q_fix;
      MD_OP_REM, MD_OP_REMU: fin_res = r_fix;
      default:               fin_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MD_ST_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      neg_q_q      <= 1'b0;
      neg_r_q      <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else if (flush) begin
      state_q     <= MD_ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        MD_ST_IDLE: begin
          if (bus.in_valid) begin
            op_q       <= op;
            neg_q_q    <= a_neg ^ b_neg;
            neg_r_q    <= a_neg;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (special || fast_hit) begin
              out_result_q <= special ? special_res : fast_res;
              out_valid_q  <= 1'b1;
              state_q      <= MD_ST_DONE;
            end else begin
              state_q <= MD_ST_CALC;
            end
          end
        end
        MD_ST_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MD_STEPS - 1)) state_q <= MD_ST_FIN;
        end
        MD_ST_FIN: begin
          out_result_q <= fin_res;
          out_valid_q  <= 1'b1;
          state_q      <= MD_ST_DONE;
        end
        MD_ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= MD_ST_IDLE;
          end
        end
        default: state_q <= MD_ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign dbg_state_o    = state_q;

endmodule
